fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_unit_skid.sv | 78 +++++++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: control states, default reset PC, address helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

  // Default PC loaded at reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Byte stride between consecutive instructions.
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // BUBBLE: nothing presented. RUN: memory data presented live.
  // HOLD: a stalled instruction is replayed from the hold register.
  typedef enum logic [1:0] {
    ST_BUBBLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2
  } fetch_state_e;

  // Drop the byte-offset bits so fetches always land on a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // A redirect target is misaligned when either byte-offset bit is set.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_skid.sv
// Fetch control FSM plus hold register that replays the instruction under stall.
// Latency: outputs are a function of registered state; decisions take effect next edge.
// Backpressure: stall in RUN captures imem data into the hold register; redirect overrides stall.
module fetch_unit_skid
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] imem_rdata_i,
  output logic        advance_o,
  output logic        redirect_ack_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  hold_instr_q, hold_instr_d;

  // State and hold register; reset discards any replayed instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BUBBLE;
      hold_instr_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Next state, hold capture and per-cycle control to the PC datapath.
  always_comb begin
    state_d        = state_q;
    hold_instr_d   = hold_instr_q;
    advance_o      = 1'b0;
    redirect_ack_o = 1'b0;
    instr_o        = imem_rdata_i;
    instr_valid_o  = 1'b0;
    case (state_q)
      ST_BUBBLE: begin
        // Bubble always refills; stall and redirects are ignored here.
        advance_o = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        instr_valid_o = 1'b1;
        instr_o       = imem_rdata_i;
        if (redirect_i) begin
          redirect_ack_o = 1'b1;
          state_d        = ST_BUBBLE;
        end else if (stall_i) begin
          // Memory moves on to the next address, so keep this word locally.
          hold_instr_d = imem_rdata_i;
          state_d      = ST_HOLD;
        end else begin
          advance_o = 1'b1;
        end
      end
      ST_HOLD: begin
        instr_valid_o = 1'b1;
        instr_o       = hold_instr_q;
        if (redirect_i) begin
          redirect_ack_o = 1'b1;
          state_d        = ST_BUBBLE;
        end else if (!stall_i) begin
          // imem_addr never moved while holding, so imem data is the next word.
          advance_o = 1'b1;
          state_d   = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BUBBLE;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues PC to a 1-cycle InstMem, presents instr with its PC.
// Latency: one instruction per clk steady state; redirects cost exactly one bubble cycle.
// Backpressure: stall holds the presented instruction (replayed from skid); redirect wins over stall.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misaligned
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        misaligned_q, misaligned_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        advance;
  logic        redirect_ack;

  // Jump outranks branch when both fire in the same cycle.
  always_comb begin
    redirect        = jump | branch_taken;
    redirect_target = jump ? jump_target : branch_target;
  end

  fetch_unit_skid u_skid (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall),
    .redirect_i     (redirect),
    .imem_rdata_i   (imem_rdata),
    .advance_o      (advance),
    .redirect_ack_o (redirect_ack),
    .instr_o        (instr),
    .instr_valid_o  (instr_valid)
  );

  // PC arithmetic: accepted redirect loads aligned target, advance steps by one word.
  always_comb begin
    pc_d         = pc_q;
    out_pc_d     = out_pc_q;
    misaligned_d = 1'b0;
    if (redirect_ack) begin
      pc_d         = word_align(redirect_target);
      out_pc_d     = pc_q;
      misaligned_d = is_misaligned(redirect_target);
    end else if (advance) begin
      // Wraps naturally from FFFF_FFFC to 0000_0000.
      pc_d     = pc_q + INSTR_BYTES;
      out_pc_d = pc_q;
    end
  end

  // PC registers and the one-cycle misaligned pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      out_pc_q     <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      out_pc_q     <= out_pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  // out_pc_q tracks the address whose data is currently on imem_rdata / hold.
  always_comb begin
    imem_addr  = pc_q;
    instr_pc   = out_pc_q;
    pc_plus4   = out_pc_q + INSTR_BYTES;
    misaligned = misaligned_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (reset PC 0 and FFFF_FFFC) share stimulus.
// Each is checked against an instruction-stream model every cycle.
// Stimulus: directed scenarios followed by randomized stall/redirect/reset traffic.
module tb_fetch_unit;

  localparam logic [31:0] RPC_LO = 32'h0000_0000;
  localparam logic [31:0] RPC_HI = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;

  logic [31:0] imem_addr_lo, imem_rdata_lo, instr_lo, instr_pc_lo, pc_plus4_lo;
  logic        instr_valid_lo, misaligned_lo;
  logic [31:0] imem_addr_hi, imem_rdata_hi, instr_hi, instr_pc_hi, pc_plus4_hi;
  logic        instr_valid_hi, misaligned_hi;

  int n_cmp = 0;
  int n_err = 0;

  // Stream model: is an instruction presented, its address, where to resume after a bubble.
  logic        m_valid  [2];
  logic [31:0] m_pc     [2];
  logic [31:0] m_resume [2];
  logic        m_mis    [2];
  logic [31:0] m_rpc    [2];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC_LO)) dut_lo (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr_lo), .imem_rdata(imem_rdata_lo),
    .instr(instr_lo), .instr_pc(instr_pc_lo), .pc_plus4(pc_plus4_lo),
    .instr_valid(instr_valid_lo), .misaligned(misaligned_lo)
  );

  fetch_unit #(.RESET_PC(RPC_HI)) dut_hi (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr_hi), .imem_rdata(imem_rdata_hi),
    .instr(instr_hi), .instr_pc(instr_pc_hi), .pc_plus4(pc_plus4_hi),
    .instr_valid(instr_valid_hi), .misaligned(misaligned_hi)
  );

  // InstMem contents: word i holds A000_0000 + i.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous-read instruction memories, one per instance.
  always @(posedge clk) begin
    imem_rdata_lo <= word_at(imem_addr_lo);
    imem_rdata_hi <= word_at(imem_addr_hi);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int k, output logic v, output logic [31:0] pc,
                         output logic [31:0] ins, output logic [31:0] p4,
                         output logic mis, output logic [31:0] addr);
    if (k == 0) begin
      v = instr_valid_lo; pc = instr_pc_lo; ins = instr_lo;
      p4 = pc_plus4_lo; mis = misaligned_lo; addr = imem_addr_lo;
    end else begin
      v = instr_valid_hi; pc = instr_pc_hi; ins = instr_hi;
      p4 = pc_plus4_hi; mis = misaligned_hi; addr = imem_addr_hi;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k]  = 1'b0;
      m_resume[k] = m_rpc[k];
      m_pc[k]     = m_rpc[k];
      m_mis[k]    = 1'b0;
    end
  endtask

  // One clock of the stream model, using the inputs applied during that cycle.
  task automatic model_step(input int k);
    logic [31:0] t;
    if (!m_valid[k]) begin
      m_valid[k] = 1'b1;
      m_pc[k]    = m_resume[k];
      m_mis[k]   = 1'b0;
    end else if (jump || branch_taken) begin
      t           = jump ? jump_target : branch_target;
      m_valid[k]  = 1'b0;
      m_resume[k] = {t[31:2], 2'b00};
      m_mis[k]    = (t[1:0] != 2'b00);
    end else begin
      m_mis[k] = 1'b0;
      if (!stall) m_pc[k] = m_pc[k] + 32'd4;
    end
  endtask

  task automatic check_cycle(input int k);
    logic v, mis;
    logic [31:0] pc, ins, p4, addr;
    get_obs(k, v, pc, ins, p4, mis, addr);
    chk($sformatf("valid%0d", k), {31'd0, v}, {31'd0, m_valid[k]});
    chk($sformatf("misaligned%0d", k), {31'd0, mis}, {31'd0, m_mis[k]});
    if (m_valid[k]) begin
      chk($sformatf("instr_pc%0d", k), pc, m_pc[k]);
      chk($sformatf("instr%0d", k), ins, word_at(m_pc[k]));
      chk($sformatf("pc_plus4_%0d", k), p4, m_pc[k] + 32'd4);
    end
  endtask

  task automatic check_reset(input int k);
    logic v, mis;
    logic [31:0] pc, ins, p4, addr;
    get_obs(k, v, pc, ins, p4, mis, addr);
    chk($sformatf("rst_valid%0d", k), {31'd0, v}, 32'd0);
    chk($sformatf("rst_mis%0d", k), {31'd0, mis}, 32'd0);
    chk($sformatf("rst_addr%0d", k), addr, m_rpc[k]);
    chk($sformatf("rst_pc%0d", k), pc, m_rpc[k]);
    chk($sformatf("rst_p4_%0d", k), p4, m_rpc[k] + 32'd4);
  endtask

  // Called at a negedge: asserts reset mid-cycle, checks, releases on a later negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset(0);
    check_reset(1);
    @(posedge clk);
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    check_cycle(0);
    check_cycle(1);
  endtask

  task automatic cyc(input logic st, input logic br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt);
    stall = st; branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_cycle(0);
    check_cycle(1);
  endtask

  initial begin
    m_rpc[0] = RPC_LO;
    m_rpc[1] = RPC_HI;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;
    model_reset();
    @(negedge clk);

    // Free run from reset: bubble, then 0,4,8 (lo) and FFFFFFFC, 0 wrap (hi).
    do_reset();
    cyc(0, 0, 0, 0, 0);
    chk("hi_first_pc", instr_pc_hi, 32'hFFFF_FFFC);
    chk("hi_first_instr", instr_hi, 32'hDFFF_FFFF);
    cyc(0, 0, 0, 0, 0);
    chk("hi_wrap_pc", instr_pc_hi, 32'h0000_0000);
    chk("hi_wrap_instr", instr_hi, 32'hA000_0000);
    cyc(0, 0, 0, 0, 0);
    chk("lo_pc8", instr_pc_lo, 32'h8);
    chk("lo_instr8", instr_lo, 32'hA000_0002);

    // Stall three cycles at pc 8: same instruction shown four cycles, then C.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("stall_instr", instr_lo, 32'hA000_0002);
    end
    cyc(0, 0, 0, 0, 0);
    chk("after_stall_pc", instr_pc_lo, 32'hC);

    // Branch to 0x40 while instr_pc is 4.
    do_reset();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("pre_branch_pc", instr_pc_lo, 32'h4);
    cyc(0, 1, 32'h40, 0, 0);
    chk("branch_bubble", {31'd0, instr_valid_lo}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("branch_pc", instr_pc_lo, 32'h40);
    chk("branch_instr", instr_lo, 32'hA000_0010);

    // Jump and branch together while in HOLD: jump wins, stall overridden.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 32'h40, 1, 32'h80);
    cyc(0, 0, 0, 0, 0);
    chk("jump_prio_pc", instr_pc_lo, 32'h80);
    chk("jump_prio_mis", {31'd0, misaligned_lo}, 32'd0);

    // Misaligned jump target 0x23.
    cyc(0, 0, 0, 1, 32'h23);
    chk("mis_pulse", {31'd0, misaligned_lo}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("mis_clear", {31'd0, misaligned_lo}, 32'd0);
    chk("mis_pc", instr_pc_lo, 32'h20);

    // Redirects presented during the bubble are ignored.
    cyc(0, 0, 0, 1, 32'h100);
    cyc(1, 1, 32'h200, 1, 32'h300);
    chk("bubble_ignore_pc", instr_pc_lo, 32'h100);

    // Reset pulsed while holding: everything discarded, restart at reset PC.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0);
    chk("restart_pc", instr_pc_lo, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 8,
            $urandom(),
            $urandom_range(0, 99) < 5,
            $urandom());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
